// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared constants, FSM encodings and baud divisor helper for uart_core
// Rev 1.0
// ============================================================================
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } rx_state_e;

    // Rounded clocks per 1/16 bit time.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + 8 * baud) / (16 * baud);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
// uart_fifo : synchronous valid/ready FIFO, power-of-two depth, extra-MSB pointers
// Rev 1.0
// ============================================================================
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             empty;
    logic             push;
    logic             pop;

    // A pop in the same cycle frees the slot, so a write into a full FIFO is accepted.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        o_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop      = ~empty & i_ready;
        push     = i_valid & (~o_full | pop);
        wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
        o_valid  = ~empty;
        o_data   = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_core.sv
`default_nettype none
// ============================================================================
// uart_core : full-duplex UART, shared 16x prescaler, oversampled RX, FIFO-buffered both ways
// Rev 1.0
// ============================================================================
module uart_core #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic                 RX_I,
    output logic                 TX_O,
    input  logic [DATA_BITS-1:0] TX_DATA_I,
    input  logic                 TX_VALID_I,
    output logic                 TX_READY_O,
    output logic [DATA_BITS-1:0] RX_DATA_O,
    output logic [1:0]           RX_ERR_O,
    output logic                 RX_VALID_O,
    input  logic                 RX_READY_I,
    output logic                 RX_OVF_O,
    input  logic                 OVF_CLR_I
);

    import uart_pkg::*;

    localparam int DIV   = calc_div(CLK_HZ, BAUD);
    localparam int PW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW    = $clog2(DATA_BITS);
    localparam int RXW   = DATA_BITS + 2;
    localparam logic ODD = (PARITY == PARITY_ODD);

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    logic [PW-1:0] presc_q, presc_d;
    logic          tick;

    always_comb begin
        tick    = (presc_q == PW'(DIV - 1));
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] txf_data;
    logic                 txf_valid;
    logic                 txf_full;
    logic                 tx_pop;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (CLK_I),
        .rst_n   (RST_I),
        .i_data  (TX_DATA_I),
        .i_valid (TX_VALID_I & ~txf_full),
        .o_full  (txf_full),
        .o_data  (txf_data),
        .o_valid (txf_valid),
        .i_ready (tx_pop)
    );

    tx_state_e            tx_state_q, tx_state_d;
    logic [3:0]           tx_cnt_q, tx_cnt_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_q, tx_d;
    logic                 tx_end;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_d       = tx_q;
        tx_pop     = 1'b0;
        tx_end     = tick && (tx_cnt_q == 4'd15);
        if (tick) begin
            tx_cnt_d = tx_cnt_q + 4'd1;
        end
        case (tx_state_q)
            TX_IDLE: begin
                tx_d     = 1'b1;
                tx_cnt_d = 4'd0;
                if (tick && txf_valid) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = txf_data;
                    tx_par_d   = (^txf_data) ^ ODD;
                    tx_state_d = TX_START;
                    tx_d       = 1'b0;
                end
            end
            TX_START: begin
                if (tx_end) begin
                    tx_state_d = TX_DATA;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                end
            end
            TX_DATA: begin
                if (tx_end) begin
                    if (tx_bit_q == BW'(DATA_BITS - 1)) begin
                        tx_bit_d = '0;
                        if (PARITY != PARITY_NONE) begin
                            tx_state_d = TX_PARITY;
                            tx_d       = tx_par_q;
                        end else begin
                            tx_state_d = TX_STOP;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        tx_bit_d   = tx_bit_q + BW'(1);
                        tx_shift_d = tx_shift_q >> 1;
                        tx_d       = tx_shift_q[1];
                    end
                end
            end
            TX_PARITY: begin
                if (tx_end) begin
                    tx_state_d = TX_STOP;
                    tx_bit_d   = '0;
                    tx_d       = 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_end) begin
                    if (tx_bit_q == BW'(STOP_BITS - 1)) begin
                        // Chain straight into the next frame so there is no idle gap.
                        if (txf_valid) begin
                            tx_pop     = 1'b1;
                            tx_shift_d = txf_data;
                            tx_par_d   = (^txf_data) ^ ODD;
                            tx_state_d = TX_START;
                            tx_d       = 1'b0;
                        end else begin
                            tx_state_d = TX_IDLE;
                        end
                    end else begin
                        tx_bit_d = tx_bit_q + BW'(1);
                    end
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_d       = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    logic rx_meta_q, rx_sync_q, rx_prev_q;
    logic rx_fall;

    assign rx_fall = rx_prev_q & ~rx_sync_q;

    rx_state_e            rx_state_q, rx_state_d;
    logic [3:0]           rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]        rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_push;
    logic                 rx_mid;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_perr_d  = rx_perr_q;
        rx_push    = 1'b0;
        rx_mid     = tick && (rx_cnt_q == 4'd15);
        if (tick) begin
            rx_cnt_d = rx_cnt_q + 4'd1;
        end
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = 4'd0;
                if (rx_fall) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                // Tick 8 after the edge: a high line means the edge was a glitch.
                if (tick && (rx_cnt_q == 4'd7)) begin
                    rx_cnt_d  = 4'd0;
                    rx_bit_d  = '0;
                    rx_perr_d = 1'b0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_mid) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    rx_bit_d   = rx_bit_q + BW'(1);
                    if (rx_bit_q == BW'(DATA_BITS - 1)) begin
                        rx_state_d = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_mid) begin
                    rx_perr_d  = rx_sync_q ^ (^rx_shift_q) ^ ODD;
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_mid) begin
                    rx_push    = 1'b1;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_BREAK;
                end
            end
            RX_BREAK: begin
                if (rx_sync_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    logic [RXW-1:0] rxf_data;
    logic           rxf_full;
    logic           rx_pop;
    logic           ovf_q, ovf_d;

    uart_fifo #(
        .WIDTH (RXW),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk     (CLK_I),
        .rst_n   (RST_I),
        .i_data  ({~rx_sync_q, rx_perr_q, rx_shift_q}),
        .i_valid (rx_push),
        .o_full  (rxf_full),
        .o_data  (rxf_data),
        .o_valid (RX_VALID_O),
        .i_ready (RX_READY_I)
    );

    always_comb begin
        rx_pop = RX_VALID_O & RX_READY_I;
        ovf_d  = (rx_push & rxf_full & ~rx_pop) | (ovf_q & ~OVF_CLR_I);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            presc_q    <= '0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_perr_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
            rx_meta_q  <= RX_I;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_perr_q  <= rx_perr_d;
            ovf_q      <= ovf_d;
        end
    end

    assign TX_O       = tx_q;
    assign TX_READY_O = ~txf_full;
    assign RX_DATA_O  = rxf_data[DATA_BITS-1:0];
    assign RX_ERR_O   = rxf_data[RXW-1:DATA_BITS];
    assign RX_OVF_O   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_core.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_uart_core : randomized self-checking bench, 8E1 at 16 clocks per bit, 4-deep FIFOs
// Rev 1.0
// ============================================================================
module tb_uart_core;

    localparam int CLK_HZ     = 16000000;
    localparam int BAUD       = 1000000;
    localparam int DB         = 8;
    localparam int PAR        = 2;
    localparam int SB         = 1;
    localparam int DEPTH      = 4;
    localparam int FB         = 1 + DB + ((PAR != 0) ? 1 : 0) + SB;
    localparam int FRAME_CLKS = FB * 16;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          rx_drv   = 1'b1;
    logic          loop_en  = 1'b0;
    logic [DB-1:0] tx_data  = '0;
    logic          tx_valid = 1'b0;
    logic          rx_ready = 1'b0;
    logic          ovf_clr  = 1'b0;
    wire           tx_o;
    wire           tx_ready;
    wire [DB-1:0]  rx_data;
    wire [1:0]     rx_err;
    wire           rx_valid;
    wire           rx_ovf;
    wire           rx_i = loop_en ? tx_o : rx_drv;

    uart_core #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .DATA_BITS  (DB),
        .PARITY     (PAR),
        .STOP_BITS  (SB),
        .FIFO_DEPTH (DEPTH)
    ) u_dut (
        .CLK_I      (clk),
        .RST_I      (rst_n),
        .RX_I       (rx_i),
        .TX_O       (tx_o),
        .TX_DATA_I  (tx_data),
        .TX_VALID_I (tx_valid),
        .TX_READY_O (tx_ready),
        .RX_DATA_O  (rx_data),
        .RX_ERR_O   (rx_err),
        .RX_VALID_O (rx_valid),
        .RX_READY_I (rx_ready),
        .RX_OVF_O   (rx_ovf),
        .OVF_CLR_I  (ovf_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: frame layout and FIFO-limited receive queue.
    function automatic logic par_bit(input logic [DB-1:0] d);
        int ones = 0;
        for (int i = 0; i < DB; i++) ones += int'(d[i]);
        return (PAR == 1) ? logic'((ones % 2) == 0) : logic'((ones % 2) == 1);
    endfunction

    function automatic logic [FB-1:0] tx_frame(input logic [DB-1:0] d);
        return {{SB{1'b1}}, par_bit(d), d, 1'b0};
    endfunction

    logic [DB+1:0] rx_exp_q[$];
    logic [DB-1:0] tx_exp_q[$];
    logic          exp_ovf = 1'b0;

    task automatic model_rx(input logic [DB-1:0] d, input logic perr, input logic ferr);
        if (rx_exp_q.size() < DEPTH) rx_exp_q.push_back({ferr, perr, d});
        else exp_ovf = 1'b1;
    endtask

    // TX line decoder: records the start cycle and mid-bit samples of every frame.
    int            tx_t_q[$];
    logic [FB-1:0] tx_f_q[$];

    initial begin : tx_mon
        logic          prev;
        logic [FB-1:0] f;
        int            t0;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev && !tx_o) begin
                t0 = cyc;
                f  = '0;
                repeat (8) @(negedge clk);
                f[0] = tx_o;
                for (int b = 1; b < FB; b++) begin
                    repeat (16) @(negedge clk);
                    f[b] = tx_o;
                end
                tx_t_q.push_back(t0);
                tx_f_q.push_back(f);
            end
            prev = tx_o;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_frame(input logic [DB-1:0] d, input logic flip, input logic stop);
        logic [FB-1:0] f;
        f = tx_frame(d);
        f[DB+1] = f[DB+1] ^ flip;
        f[DB+2] = stop;
        for (int b = 0; b < FB; b++) begin
            rx_drv = f[b];
            wait_clks(16);
        end
        model_rx(d, flip, ~stop);
    endtask

    task automatic push_burst(input int n);
        logic [DB-1:0] d;
        int            drops = 0;
        for (int i = 0; i < n; i++) begin
            d        = DB'($urandom_range(0, 255));
            tx_exp_q.push_back(d);
            tx_data  = d;
            tx_valid = 1'b1;
            if (!tx_ready) drops++;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check("tx_ready_held", 32'(drops), 32'd0);
    endtask

    task automatic check_tx_frames();
        check("tx_frame_count", 32'(tx_f_q.size()), 32'(tx_exp_q.size()));
        for (int i = 0; i < tx_exp_q.size() && i < tx_f_q.size(); i++) begin
            check("tx_frame_bits", 32'(tx_f_q[i]), 32'(tx_frame(tx_exp_q[i])));
            if (i > 0) check("tx_frame_gap", 32'(tx_t_q[i] - tx_t_q[i-1]), 32'(FRAME_CLKS));
            model_rx(tx_exp_q[i], 1'b0, 1'b0);
        end
        tx_exp_q.delete();
        tx_f_q.delete();
        tx_t_q.delete();
    endtask

    task automatic pop_all(input string tag);
        logic [DB+1:0] e;
        while (rx_exp_q.size() > 0) begin
            e = rx_exp_q.pop_front();
            check(tag, 32'({rx_valid, rx_err, rx_data}), 32'({1'b1, e}));
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
        check("rx_empty", 32'(rx_valid), 32'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        wait_clks(3);
        check("reset_tx_o", 32'(tx_o), 32'd1);
        check("reset_tx_ready", 32'(tx_ready), 32'd1);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_rx_ovf", 32'(rx_ovf), 32'd0);
        rst_n = 1'b1;
        wait_clks(5);

        // Loopback bursts with TX_VALID held high.
        loop_en = 1'b1;
        push_burst(3);
        wait_clks(3 * FRAME_CLKS + 40);
        check_tx_frames();
        pop_all("loop_rx_3");
        push_burst(4);
        wait_clks(4 * FRAME_CLKS + 40);
        check_tx_frames();
        check("loop_no_ovf", 32'(rx_ovf), 32'd0);
        pop_all("loop_rx_4");

        // Parity: 0x55 good, 0x55 flipped, then random bytes and flips.
        loop_en = 1'b0;
        wait_clks(20);
        drive_frame(8'h55, 1'b0, 1'b1);
        drive_frame(8'h55, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            drive_frame(DB'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1);
            wait_clks($urandom_range(0, 12));
        end
        wait_clks(10);
        pop_all("parity_rx");

        // Short glitch fails the start check.
        rx_drv = 1'b0;
        wait_clks(4);
        rx_drv = 1'b1;
        wait_clks(40);
        check("glitch_no_push", 32'(rx_valid), 32'd0);

        // Bad stop bit extended into a long low, then a clean frame.
        drive_frame(8'hA5, 1'b0, 1'b0);
        wait_clks(80);
        rx_drv = 1'b1;
        wait_clks(3);
        drive_frame(DB'($urandom_range(0, 255)), 1'b0, 1'b1);
        wait_clks(10);
        pop_all("break_rx");

        // Overflow with the reader stalled.
        for (int i = 0; i < DEPTH + 1; i++) begin
            drive_frame(DB'($urandom_range(0, 255)), 1'b0, 1'b1);
            wait_clks($urandom_range(0, 10));
            check("ovf_flag", 32'(rx_ovf), 32'(exp_ovf));
        end
        pop_all("ovf_rx");
        check("ovf_sticky", 32'(rx_ovf), 32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        exp_ovf = 1'b0;
        check("ovf_cleared", 32'(rx_ovf), 32'd0);

        // Asynchronous reset in the middle of a TX data bit.
        loop_en = 1'b1;
        wait_clks(5);
        push_burst(1);
        wait_clks(16 * 3 + 8);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tx_o", 32'(tx_o), 32'd1);
        check("async_rst_ready", 32'(tx_ready), 32'd1);
        check("async_rst_rx_valid", 32'(rx_valid), 32'd0);
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(200);
        check("post_rst_rx_valid", 32'(rx_valid), 32'd0);
        tx_exp_q.delete();
        tx_f_q.delete();
        tx_t_q.delete();
        push_burst(1);
        wait_clks(FRAME_CLKS + 40);
        check_tx_frames();
        pop_all("post_rst_rx");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
